// File: rtl/rv_pkg.sv
// Shared register-file constants: default widths, register count and the hardwired-zero index.
// Combinational and registered stages elsewhere take their defaults from here.
package rv_pkg;
    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int REG_AW   = $clog2(NREG);
    localparam int REG_ZERO = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Write-pending scoreboard: one pending bit per register, set on issue, cleared on write-back.
// Latency: iss_ok is combinational; pend_vec updates on the next rising edge.
// Backpressure: iss_ok=0 stalls decode, which holds iss_addr and retries with no state change.
module rf_scoreboard #(
    parameter int NREG = rv_pkg::NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic            iss_ok,
    output logic [NREG-1:0] pend_vec
);
    import rv_pkg::*;

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic            wr_live;
    logic            iss_live;

    assign wr_live  = wr_en && (wr_addr != AW'(REG_ZERO));
    // A write landing this cycle retires the old producer, so a new reservation may proceed.
    assign iss_ok   = (iss_addr == AW'(REG_ZERO)) || !pend_q[iss_addr]
                      || (wr_en && (wr_addr == iss_addr));
    assign iss_live = iss_en && iss_ok && (iss_addr != AW'(REG_ZERO));

    // Set is applied after clear so a new producer stays outstanding.
    always_comb begin
        pend_d = pend_q;
        if (wr_live) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (iss_live) begin
            pend_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_vec = pend_q;
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with hardwired-zero x0 and write-pending scoreboard.
// Latency: reads zero-cycle combinational; writes visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none on reads/writes; issue stalls via iss_ok when the destination is still pending.
module reg_file_sb #(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int NREG = rv_pkg::NREG,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ok,
    output logic [NREG-1:0]     pend_vec
);
    import rv_pkg::*;

    logic [XLEN-1:0] regs [NREG];

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_ok   (iss_ok),
        .pend_vec (pend_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            data = '0;
            busy = 1'b0;
            if (addr != AW'(REG_ZERO)) begin
                data = regs[addr];
                busy = pend_vec[addr];
`ifdef REGFILE_BYPASS_EN
                // Forwarded value belongs to this consumer even if the reg is re-reserved now.
                if (wr_en && (wr_addr == addr)) begin
                    data = wr_data;
                    busy = 1'b0;
                end
`endif
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_busy[k]              = busy;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic against an array/bit-vector model,
// and a 3-port 16x64 instance read on all ports at once.
module tb_reg_file_sb;
    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ok;
    logic [31:0] pend_vec;

    logic         b_rst;
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic         b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_iss_en;
    logic [3:0]   b_iss_addr;
    logic         b_iss_ok;
    logic [15:0]  b_pend_vec;

    int npass = 0;
    int nfail = 0;
    int ntotal = 0;

    logic [31:0] mregs [32];
    logic        mpend [32];
    logic [63:0] bvals [16];

    reg_file_sb u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ok(iss_ok), .pend_vec(pend_vec)
    );

    reg_file_sb #(.XLEN(64), .NREG(16), .NRD(3)) u_dut3 (
        .clk(clk), .rst(b_rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .iss_en(b_iss_en),
        .iss_addr(b_iss_addr), .iss_ok(b_iss_ok), .pend_vec(b_pend_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return mregs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return 1'b0;
`endif
        return mpend[a];
    endfunction

    function automatic logic exp_iss_ok();
        return (iss_addr == 5'd0) || !mpend[iss_addr] || (wr_en && wr_addr == iss_addr);
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] pv;
        for (int i = 0; i < 32; i++) pv[i] = mpend[i];
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s rd_data%0d", tag, k), rd_data[k*32 +: 32], exp_data(rd_addr[k*5 +: 5]));
            chk($sformatf("%s rd_busy%0d", tag, k), rd_busy[k], exp_busy(rd_addr[k*5 +: 5]));
        end
        chk({tag, " iss_ok"}, iss_ok, exp_iss_ok());
        chk({tag, " pend_vec"}, pend_vec, pv);
    endtask

    // Applies the currently driven inputs to the model, as the coming clock edge will.
    task automatic model_update();
        logic ok;
        ok = exp_iss_ok();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] = '0;
                mpend[i] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                mregs[wr_addr] = wr_data;
                mpend[wr_addr] = 1'b0;
            end
            if (iss_en && ok && iss_addr != 5'd0) mpend[iss_addr] = 1'b1;
        end
    endtask

    task automatic go(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia, input logic [4:0] r0,
                      input logic [4:0] r1, input string tag);
        model_update();
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; rd_addr = {r1, r0};
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [3:0] a0, a1, a2;
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mpend[i] = 1'b0;
        end
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
        b_rst = 1'b1; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_iss_en = 1'b0; b_iss_addr = '0; b_rd_addr = '0;

        // Reset state and reset clearing a written register
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'd5, 5'd0, "post_reset");
        chk("reset rd_data0", rd_data[31:0], 32'h0);
        chk("reset rd_busy", rd_busy, 2'b00);
        chk("reset pend_vec", pend_vec, 32'h0);
        chk("reset iss_ok", iss_ok, 1'b1);
        go(1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 5'd5, 5'd0, "wr_x5");
        go(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 5'd5, 5'd6, "rst_mid");
        chk("pre_rst x5", rd_data[31:0], 32'hDEAD);
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, 5'd6, "after_rst");
        chk("after_rst x5", rd_data[31:0], 32'h0);
        chk("after_rst x6", rd_data[63:32], 32'h0);
        chk("after_rst pend_vec", pend_vec, 32'h0);

        // x0 writes and issues have no effect
        go(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, "x0_wr_iss");
        chk("x0 iss_ok", iss_ok, 1'b1);
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, "x0_read");
        chk("x0 rd_data", rd_data[31:0], 32'h0);
        chk("x0 rd_busy", rd_busy[0], 1'b0);
        chk("x0 pend", pend_vec[0], 1'b0);

        // RAW: reserve x7, read busy, write, read value
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, "raw_iss");
        chk("raw iss_ok", iss_ok, 1'b1);
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, "raw_pend");
        chk("raw busy", rd_busy, 2'b11);
        go(1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd7, 5'd0, "raw_wr");
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, "raw_rd");
        chk("raw rd_data", rd_data[31:0], 32'h1234);
        chk("raw rd_busy", rd_busy[0], 1'b0);

        // WAW: second reservation stalls until the write lands, then stays pending
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, "waw_iss1");
        chk("waw first iss_ok", iss_ok, 1'b1);
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, "waw_iss2");
        chk("waw stall iss_ok", iss_ok, 1'b0);
        go(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd0, "waw_retry");
        chk("waw stall pend", pend_vec[3], 1'b1);
        chk("waw retry iss_ok", iss_ok, 1'b1);
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, "waw_after");
        chk("waw pend stays", pend_vec[3], 1'b1);
        chk("waw data", rd_data[31:0], 32'h33);
        chk("waw busy", rd_busy[0], 1'b1);

        // Write/read collision on port 1
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9, "byp_iss");
        go(1'b0, 1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd0, 5'd0, 5'd9, "byp_wr");
`ifdef REGFILE_BYPASS_EN
        chk("byp rd_data1", rd_data[63:32], 32'hCAFE);
        chk("byp rd_busy1", rd_busy[1], 1'b0);
`else
        chk("nobyp rd_data1", rd_data[63:32], 32'h0);
        chk("nobyp rd_busy1", rd_busy[1], 1'b1);
`endif
        go(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9, "byp_after");
        chk("byp after data", rd_data[63:32], 32'hCAFE);

        // Random traffic on a narrow address window to force collisions
        for (int n = 0; n < 400; n++) begin
            go(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $sformatf("rand%0d", n));
        end
        model_update();

        // Three-port 16x64 instance: fill, then read distinct registers on all ports
        @(negedge clk);
        b_rst = 1'b0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            b_wr_en   = 1'b1;
            b_wr_addr = 4'(i);
            b_wr_data = {$urandom, $urandom};
            bvals[i]  = b_wr_data;
        end
        @(negedge clk);
        b_wr_en = 1'b0;
        for (int t = 0; t < 8; t++) begin
            a0 = 4'($urandom_range(1, 15));
            a1 = 4'(((a0 + $urandom_range(1, 7) - 1) % 15) + 1);
            a2 = 4'(((a0 + $urandom_range(8, 14) - 1) % 15) + 1);
            @(negedge clk);
            b_rd_addr = {a2, a1, a0};
            #1;
            chk($sformatf("p3 port0 x%0d", a0), b_rd_data[63:0], bvals[a0]);
            chk($sformatf("p3 port1 x%0d", a1), b_rd_data[127:64], bvals[a1]);
            chk($sformatf("p3 port2 x%0d", a2), b_rd_data[191:128], bvals[a2]);
            chk("p3 busy", b_rd_busy, 3'b000);
        end
        @(negedge clk);
        b_rd_addr = {4'd15, 4'd0, 4'd1};
        #1;
        chk("p3 x0", b_rd_data[127:64], 64'h0);
        chk("p3 x15", b_rd_data[191:128], bvals[15]);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
